// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - read/write bus bundle for the register file
//
// Purpose: groups the read ports, the write port and the write-blocking
// finish_flag of register_file into one bundle.
// Signals:
//   Read1, Read2  register indices for the two read ports
//   RD            write register index
//   WriteData     data to write
//   RegWrite      write enable, active high
//   finish_flag   high blocks all writes
//   Data1, Data2  read data for Read1 / Read2
// Modports: master drives indices/write side and samples read data;
//           slave is the register file itself.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] Read1;
  logic [ADDR_WIDTH-1:0] Read2;
  logic [ADDR_WIDTH-1:0] RD;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic                  finish_flag;
  logic [DATA_WIDTH-1:0] Data1;
  logic [DATA_WIDTH-1:0] Data2;

  modport master (
    output Read1, Read2, RD, WriteData, RegWrite, finish_flag,
    input  Data1, Data2
  );

  modport slave (
    input  Read1, Read2, RD, WriteData, RegWrite, finish_flag,
    output Data1, Data2
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x 32 RISC-V general-purpose register file
//
// Purpose: two combinational read ports and one synchronous write port;
// x0 is hardwired to zero. finish_flag freezes the array contents.
// Optional feature macro: REGFILE_BYPASS_EN (write-through forwarding of a
// qualifying write onto a read port addressing the same register).
// Ports:
//   clock    system clock, state updates on the rising edge
//   reset_n  synchronous active-low reset, clears every register
//   bus      register_file_if.slave: Read1/Read2/RD/WriteData/RegWrite/
//            finish_flag in, Data1/Data2 out
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic          clock,
  input  logic          reset_n,
  register_file_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  write_en;

  // Write to x0 is dropped here, so regs[0] stays zero after reset; the read
  // mux still forces zero so x0 never depends on the array contents.
  assign write_en = bus.RegWrite && !bus.finish_flag && (bus.RD != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (write_en) begin
      regs[bus.RD] <= bus.WriteData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding also requires reset_n high: a write that reset overrides must
  // not appear on the read ports.
  logic fwd_ok;
  assign fwd_ok = write_en && reset_n;

  always_comb begin
    bus.Data1 = (bus.Read1 == '0) ? '0 : regs[bus.Read1];
    bus.Data2 = (bus.Read2 == '0) ? '0 : regs[bus.Read2];
    if (fwd_ok && (bus.Read1 == bus.RD)) begin
      bus.Data1 = bus.WriteData;
    end
    if (fwd_ok && (bus.Read2 == bus.RD)) begin
      bus.Data2 = bus.WriteData;
    end
  end
`else
  always_comb begin
    bus.Data1 = (bus.Read1 == '0) ? '0 : regs[bus.Read1];
    bus.Data2 = (bus.Read2 == '0) ? '0 : regs[bus.Read2];
  end
`endif
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; inputs may be changed right after return.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [DW-1:0] same_exp;
    tests_run    = 0;
    tests_failed = 0;
    reset_n          = 1'b0;
    bus.Read1        = '0;
    bus.Read2        = '0;
    bus.RD           = 5'd4;
    bus.WriteData    = 32'hDEADBEEF;
    bus.RegWrite     = 1'b1;
    bus.finish_flag  = 1'b0;

    // Reset (with a competing write) then read
    tick();
    reset_n      = 1'b1;
    bus.RegWrite = 1'b0;
    bus.Read1    = 5'd7;
    bus.Read2    = 5'd10;
    #1;
    check("reset_r7", bus.Data1, 32'h0);
    check("reset_r10", bus.Data2, 32'h0);
    bus.Read1 = 5'd4;
    bus.Read2 = 5'd31;
    #1;
    check("reset_beats_write_r4", bus.Data1, 32'h0);
    check("reset_r31", bus.Data2, 32'h0);

    // Write / read back
    bus.RegWrite  = 1'b1;
    bus.RD        = 5'd3;
    bus.WriteData = 32'hABCDEFFF;
    tick();
    bus.RD        = 5'd5;
    bus.WriteData = 32'hFBCDE111;
    tick();
    bus.RD        = 5'd31;
    bus.WriteData = 32'h80000001;
    tick();
    bus.RegWrite = 1'b0;
    bus.Read1    = 5'd3;
    bus.Read2    = 5'd5;
    #1;
    check("wr_r3", bus.Data1, 32'hABCDEFFF);
    check("wr_r5", bus.Data2, 32'hFBCDE111);
    bus.Read1 = 5'd31;
    bus.Read2 = 5'd31;
    #1;
    check("wr_r31_p1", bus.Data1, 32'h80000001);
    check("wr_r31_p2", bus.Data2, 32'h80000001);

    // RegWrite=0 must not write
    bus.RD        = 5'd5;
    bus.WriteData = 32'h0000_0BAD;
    tick();
    bus.Read2 = 5'd5;
    #1;
    check("nowrite_r5", bus.Data2, 32'hFBCDE111);

    // x0 protection
    bus.RegWrite  = 1'b1;
    bus.RD        = 5'd0;
    bus.WriteData = 32'hFFFFFFFF;
    tick();
    bus.RegWrite = 1'b0;
    bus.Read1    = 5'd0;
    bus.Read2    = 5'd3;
    #1;
    check("x0_zero", bus.Data1, 32'h0);
    check("x0_r3_kept", bus.Data2, 32'hABCDEFFF);

    // finish_flag blocks writes, reads still work
    bus.finish_flag = 1'b1;
    bus.RegWrite    = 1'b1;
    bus.RD          = 5'd3;
    bus.WriteData   = 32'h12345678;
    bus.Read1       = 5'd3;
    bus.Read2       = 5'd5;
    #1;
    check("finish_no_fwd", bus.Data1, 32'hABCDEFFF);
    tick();
    check("finish_r3", bus.Data1, 32'hABCDEFFF);
    check("finish_r5", bus.Data2, 32'hFBCDE111);

    // Reset mid-operation, with finish_flag still high
    reset_n       = 1'b0;
    bus.RD        = 5'd5;
    bus.WriteData = 32'h1;
    tick();
    reset_n = 1'b1;
    bus.RegWrite    = 1'b0;
    bus.finish_flag = 1'b0;
    bus.Read1 = 5'd3;
    bus.Read2 = 5'd5;
    #1;
    check("midrst_r3", bus.Data1, 32'h0);
    check("midrst_r5", bus.Data2, 32'h0);
    bus.Read1 = 5'd31;
    #1;
    check("midrst_r31", bus.Data1, 32'h0);

    // Same-index read/write
    bus.Read1     = 5'd9;
    bus.Read2     = 5'd9;
    bus.RD        = 5'd9;
    bus.WriteData = 32'h55AA55AA;
    bus.RegWrite  = 1'b1;
    #1;
    same_exp = BYPASS ? 32'h55AA55AA : 32'h0;
    check("same_before_p1", bus.Data1, same_exp);
    check("same_before_p2", bus.Data2, same_exp);
    tick();
    bus.RegWrite = 1'b0;
    #1;
    check("same_after_p1", bus.Data1, 32'h55AA55AA);
    check("same_after_p2", bus.Data2, 32'h55AA55AA);

    // Rewrite with held RegWrite, different data, different port pairing
    bus.RegWrite  = 1'b1;
    bus.RD        = 5'd9;
    bus.WriteData = 32'h0F0F0F0F;
    bus.Read1     = 5'd31;
    tick();
    tick();
    bus.RegWrite = 1'b0;
    #1;
    check("rewrite_r9", bus.Data2, 32'h0F0F0F0F);
    check("rewrite_r31_clear", bus.Data1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle RISC-V core.
- Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits between instruction decode and ALU; the writeback stage drives the write port.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH (32).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- Read1  input  ADDR_WIDTH  read port 1 register index (rs1).
- Read2  input  ADDR_WIDTH  read port 2 register index (rs2).
- RD  input  ADDR_WIDTH  write register index (rd).
- WriteData  input  DATA_WIDTH  data to write.
- RegWrite  input  1  write enable, active high.
- finish_flag  input  1  program-finished indication; high blocks all writes.
- Data1  output  DATA_WIDTH  contents of register Read1.
- Data2  output  DATA_WIDTH  contents of register Read2.

Behaviour:
- Interface: one clock (clock); reset (reset_n) is synchronous and active-low.
- Reset:
  - On a rising clock edge with reset_n=0, all 32 registers clear to 0.
  - Reset has priority over any write in the same cycle.
  - Data1/Data2 therefore read 0 for every index from the cycle after reset.
- Write:
  - Occurs on a rising clock edge when reset_n=1, RegWrite=1, finish_flag=0 and RD!=0.
  - Effect: reg[RD] <= WriteData.
  - With RegWrite=1 held across several edges, every edge rewrites (idempotent for constant inputs).
- Write to RD=0 is silently discarded; x0 always reads 0.
- finish_flag=1 suppresses writes regardless of RegWrite.
  - Registers hold their values; reads remain functional.
  - Reset still clears registers while finish_flag=1.
- Read:
  - Purely combinational, zero latency: Data1 = (Read1==0) ? 0 : reg[Read1]; same for Data2/Read2.
  - Both ports are independent; Read1==Read2 is legal and gives identical outputs.
- Read/write same index, same cycle:
  - Without the optional feature, the read returns the old value until the write edge, then the new value.
- X/unknown on Read1/Read2 may produce X on outputs; no other X sources.
  - Registers are never uninitialised after the first reset.
- No internal state other than the register array.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If a write qualifies this cycle (RegWrite=1, finish_flag=0, reset_n=1, RD!=0) and Read1==RD, then Data1=WriteData combinationally. Same for Data2/Read2. Array update is unchanged.
- Not defined: no forwarding; reads return array contents only, as specified above.

Test Plan:
- Reset then read: hold reset_n=0 for 1 edge, release; Read1=7, Read2=10 -> Data1=0x00000000, Data2=0x00000000.
- Write/read back: RegWrite=1, RD=3, WriteData=0xABCDEFFF, one edge; RD=5, WriteData=0xFBCDE111, one edge; RegWrite=0; Read1=3, Read2=5 -> Data1=0xABCDEFFF, Data2=0xFBCDE111.
- x0 protection: RegWrite=1, RD=0, WriteData=0xFFFFFFFF, edge; Read1=0 -> Data1=0x00000000.
- finish_flag block: reg3=0xABCDEFFF; finish_flag=1, RegWrite=1, RD=3, WriteData=0x12345678, edge; Read1=3 -> 0xABCDEFFF.
- Reset mid-operation: reg5=0xFBCDE111; reset_n=0 together with RegWrite=1, RD=5, WriteData=0x1, edge; Read2=5 -> 0x00000000.
- Same-index read/write: Read1=9, RD=9, WriteData=0x55AA55AA, RegWrite=1.
  - Before edge: Data1=0 without REGFILE_BYPASS_EN, 0x55AA55AA with it.
  - After edge: 0x55AA55AA in both builds.
